// File: rtl/abus_encoding.sv
// rtl/abus_encoding.sv - shared abus state encoding and strobe-width helper
//
// Purpose : constants shared by the abus master and slave blocks.
// Contents: abus_state_e  - 2-bit responder state encoding
//           strb_width()  - width of the strobe/keep count fields for a data width
package abus_encoding;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_ACK      = 2'd2,
    S_WAIT_REL = 2'd3
  } abus_state_e;

  // Strobe/keep carry a count 0..DATA_WIDTH, hence DATA_WIDTH+1 values.
  function automatic int strb_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/abus_slave_decode.sv
// rtl/abus_slave_decode.sv - combinational address window hit comparator
//
// Purpose : flags addresses that fall inside a 2**SPAN_LOG2 window at BASE_ADDR.
// Ports   : addr  in  ADDR_WIDTH  address to decode
//           hit   out 1           address is inside the window
module abus_slave_decode #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    SPAN_LOG2  = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit
);

  // Only the bits above the window offset take part in the compare.
  assign hit = (addr[ADDR_WIDTH-1:SPAN_LOG2] == BASE_ADDR[ADDR_WIDTH-1:SPAN_LOG2]);

  logic unused_offset;
  assign unused_offset = ^addr[SPAN_LOG2-1:0];

endmodule

// File: rtl/abus_slave.sv
// rtl/abus_slave.sv - abus responder bridging one address window to a local register port
//
// Purpose : decodes one address window and turns each granted master order
//           (write/read/abort) into a single local register access, then holds
//           abus_sack until the master releases abus_sreq.
// Options : ABUS_SLAVE_TIMEOUT_EN - bounds the wait for reg_ready to TIMEOUT cycles
//           and reports expiry on abus_serr; undefined, the block waits forever.
// Ports   : abus_clk, abus_rstb             clock, async active-low reset
//           abus_sreq/swrite/sread/sabort   master request and orders
//           abus_saddress/swdata            address and write data
//           abus_sstrb/skeep                strobe/keep counts, passed through
//           abus_sack/serr/srdata           acknowledge, error, read data
//           reg_req/write/addr/wdata        local access request and fields
//           reg_strb/keep                   local strobe/keep
//           reg_ready/rdata                 local completion and read data
module abus_slave
  import abus_encoding::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    SPAN_LOG2  = 8,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                              abus_clk,
  input  logic                              abus_rstb,
  input  logic                              abus_sreq,
  input  logic                              abus_swrite,
  input  logic                              abus_sread,
  input  logic                              abus_sabort,
  input  logic [ADDR_WIDTH-1:0]             abus_saddress,
  input  logic [DATA_WIDTH-1:0]             abus_swdata,
  input  logic [strb_width(DATA_WIDTH)-1:0] abus_sstrb,
  input  logic [strb_width(DATA_WIDTH)-1:0] abus_skeep,
  output logic                              abus_sack,
  output logic                              abus_serr,
  output logic [DATA_WIDTH-1:0]             abus_srdata,
  output logic                              reg_req,
  output logic                              reg_write,
  output logic [SPAN_LOG2-1:0]              reg_addr,
  output logic [DATA_WIDTH-1:0]             reg_wdata,
  output logic [strb_width(DATA_WIDTH)-1:0] reg_strb,
  output logic [strb_width(DATA_WIDTH)-1:0] reg_keep,
  input  logic                              reg_ready,
  input  logic [DATA_WIDTH-1:0]             reg_rdata
);

  localparam int SW = strb_width(DATA_WIDTH);

  abus_state_e           state_q, state_d;
  logic                  hit;
  logic                  abort_q, abort_d;
  logic                  req_d, write_d, sack_d;
  logic [SPAN_LOG2-1:0]  addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
  logic [SW-1:0]         strb_d, keep_d;

`ifdef ABUS_SLAVE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       serr_q, serr_d;
  assign abus_serr = serr_q;
`else
  assign abus_serr = 1'b0;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  abus_slave_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .SPAN_LOG2  (SPAN_LOG2)
  ) u_decode (
    .addr (abus_saddress),
    .hit  (hit)
  );

  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      state_q     <= S_IDLE;
      abort_q     <= 1'b0;
      reg_req     <= 1'b0;
      reg_write   <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_strb    <= '0;
      reg_keep    <= '0;
      abus_sack   <= 1'b0;
      abus_srdata <= '0;
`ifdef ABUS_SLAVE_TIMEOUT_EN
      tmo_q       <= '0;
      serr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      abort_q     <= abort_d;
      reg_req     <= req_d;
      reg_write   <= write_d;
      reg_addr    <= addr_d;
      reg_wdata   <= wdata_d;
      reg_strb    <= strb_d;
      reg_keep    <= keep_d;
      abus_sack   <= sack_d;
      abus_srdata <= rdata_d;
`ifdef ABUS_SLAVE_TIMEOUT_EN
      tmo_q       <= tmo_d;
      serr_q      <= serr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    req_d   = reg_req;
    write_d = reg_write;
    addr_d  = reg_addr;
    wdata_d = reg_wdata;
    strb_d  = reg_strb;
    keep_d  = reg_keep;
    sack_d  = abus_sack;
    rdata_d = abus_srdata;
`ifdef ABUS_SLAVE_TIMEOUT_EN
    tmo_d   = tmo_q;
    serr_d  = serr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (abus_sreq && hit) begin
          if (abus_sabort) begin
            // Abort with nothing in flight: acknowledge without touching the register file.
            state_d = S_ACK;
            rdata_d = '0;
          end else if (abus_swrite || abus_sread) begin
            state_d = S_ACCESS;
            req_d   = 1'b1;
            write_d = abus_swrite;
            addr_d  = abus_saddress[SPAN_LOG2-1:0];
            wdata_d = abus_swdata;
            strb_d  = abus_sstrb;
            keep_d  = abus_skeep;
            abort_d = 1'b0;
`ifdef ABUS_SLAVE_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end

      S_ACCESS: begin
        // A late abort never cuts the local access short; it only blanks the read data.
        if (abus_sabort) abort_d = 1'b1;
        if (reg_ready) begin
          req_d   = 1'b0;
          rdata_d = (reg_write || abort_q || abus_sabort) ? '0 : reg_rdata;
          state_d = S_ACK;
        end
`ifdef ABUS_SLAVE_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          req_d   = 1'b0;
          rdata_d = '0;
          serr_d  = 1'b1;
          state_d = S_ACK;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end

      S_ACK: begin
        sack_d  = 1'b1;
        state_d = S_WAIT_REL;
      end

      S_WAIT_REL: begin
        // Returning to idle here, not on the next order, guarantees an idle cycle between accesses.
        if (!abus_sreq) begin
          sack_d  = 1'b0;
          rdata_d = '0;
`ifdef ABUS_SLAVE_TIMEOUT_EN
          serr_d  = 1'b0;
`endif
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_abus_slave.sv
// tb/tb_abus_slave.sv - scoreboard testbench for abus_slave
module tb_abus_slave;

  localparam int          AW   = 16;
  localparam int          DW   = 16;
  localparam int          SW   = $clog2(DW + 1);
  localparam logic [15:0] BASE = 16'h4000;
  localparam int          SPAN = 8;
  localparam int          TMO  = 4;

  logic          abus_clk = 1'b0;
  logic          abus_rstb;
  logic          abus_sreq, abus_swrite, abus_sread, abus_sabort;
  logic [AW-1:0] abus_saddress;
  logic [DW-1:0] abus_swdata;
  logic [SW-1:0] abus_sstrb, abus_skeep;
  logic          abus_sack, abus_serr;
  logic [DW-1:0] abus_srdata;
  logic          reg_req, reg_write;
  logic [SPAN-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [SW-1:0] reg_strb, reg_keep;
  logic          reg_ready;
  logic [DW-1:0] reg_rdata;

  always #5 abus_clk = ~abus_clk;

  abus_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BASE_ADDR  (BASE),
    .SPAN_LOG2  (SPAN),
    .TIMEOUT    (TMO)
  ) dut (
    .abus_clk      (abus_clk),
    .abus_rstb     (abus_rstb),
    .abus_sreq     (abus_sreq),
    .abus_swrite   (abus_swrite),
    .abus_sread    (abus_sread),
    .abus_sabort   (abus_sabort),
    .abus_saddress (abus_saddress),
    .abus_swdata   (abus_swdata),
    .abus_sstrb    (abus_sstrb),
    .abus_skeep    (abus_skeep),
    .abus_sack     (abus_sack),
    .abus_serr     (abus_serr),
    .abus_srdata   (abus_srdata),
    .reg_req       (reg_req),
    .reg_write     (reg_write),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_strb      (reg_strb),
    .reg_keep      (reg_keep),
    .reg_ready     (reg_ready),
    .reg_rdata     (reg_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]    addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [SW-1:0] keep;
  } acc_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  // Reference register file (what the master believes) and the peripheral's own storage.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] periph  [256];

  int cur_lat = 0;
  bit hold    = 1'b0;
  int lat_cnt = 0;

  // Peripheral: answers after cur_lat extra cycles, never while hold is set.
  always @(negedge abus_clk) begin
    reg_ready = 1'b0;
    if (reg_req && !hold) begin
      if (lat_cnt >= cur_lat) begin
        reg_ready = 1'b1;
        reg_rdata = reg_write ? DW'($urandom) : periph[reg_addr];
        if (reg_write) periph[reg_addr] = reg_wdata;
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end else if (!reg_req) begin
      lat_cnt = 0;
    end
  end

  // Local-port monitor.
  logic prev_req = 1'b0;
  acc_t cur_acc;
  always @(negedge abus_clk) begin
    if (reg_req && !prev_req) begin
      if (acc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_reg_req: got reg_req=1, expected no access (t=%0t)", $time);
      end else begin
        cur_acc = acc_q.pop_front();
        chk("reg_addr",  32'(reg_addr),  32'(cur_acc.addr));
        chk("reg_write", 32'(reg_write), 32'(cur_acc.wr));
        chk("reg_wdata", 32'(reg_wdata), 32'(cur_acc.wdata));
        chk("reg_strb",  32'(reg_strb),  32'(cur_acc.strb));
        chk("reg_keep",  32'(reg_keep),  32'(cur_acc.keep));
      end
    end else if (reg_req) begin
      chk("reg_addr_stable",  32'(reg_addr),  32'(cur_acc.addr));
      chk("reg_wdata_stable", 32'(reg_wdata), 32'(cur_acc.wdata));
    end
    prev_req = reg_req;
  end

  // Response monitor.
  logic prev_sack = 1'b0;
  rsp_t cur_rsp;
  always @(negedge abus_clk) begin
    if (abus_sack && !prev_sack) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_sack: got abus_sack=1, expected no ack (t=%0t)", $time);
      end else begin
        cur_rsp = rsp_q.pop_front();
        chk("srdata", 32'(abus_srdata), 32'(cur_rsp.rdata));
        chk("serr",   32'(abus_serr),   32'(cur_rsp.err));
      end
    end else if (abus_sack) begin
      chk("srdata_hold", 32'(abus_srdata), 32'(cur_rsp.rdata));
      chk("serr_hold",   32'(abus_serr),   32'(cur_rsp.err));
    end else if (prev_sack) begin
      chk("srdata_cleared", 32'(abus_srdata), 32'h0);
      chk("serr_cleared",   32'(abus_serr),   32'h0);
    end
    prev_sack = abus_sack;
  end

  task automatic drive(input logic [15:0] addr, input int kind, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, input logic [SW-1:0] kp);
    @(negedge abus_clk);
    abus_sreq     = 1'b1;
    abus_saddress = addr;
    abus_swdata   = wd;
    abus_sstrb    = st;
    abus_skeep    = kp;
    // Lower-priority orders are sometimes raised alongside to exercise priority.
    abus_swrite   = (kind == 0) || (kind == 2 && $urandom_range(1) == 1);
    abus_sread    = (kind == 1) || ($urandom_range(1) == 1);
    abus_sabort   = (kind == 2);
  endtask

  task automatic release_bus();
    @(negedge abus_clk);
    abus_sreq   = 1'b0;
    abus_swrite = 1'b0;
    abus_sread  = 1'b0;
    abus_sabort = 1'b0;
    @(posedge abus_clk); #1;
    chk("sack_released",  32'(abus_sack),   32'h0);
    chk("srdata_zeroed",  32'(abus_srdata), 32'h0);
    @(negedge abus_clk);
  endtask

  // kind: 0 write, 1 read, 2 abort
  task automatic txn(input logic [15:0] addr, input int kind, input int lat,
                     input bit mid_abort, input logic [DW-1:0] wd);
    logic [7:0]    off;
    bit            hit;
    logic [SW-1:0] st, kp;
    int            n, exp_n;
    rsp_t          r;
    acc_t          a;
    off = addr[7:0];
    hit = (addr[15:8] == BASE[15:8]);
    st  = SW'($urandom_range(DW));
    kp  = SW'($urandom_range(DW));
    cur_lat = lat;
    if (hit && kind == 2) begin
      r.rdata = '0; r.err = 1'b0; rsp_q.push_back(r);
      exp_n = 2;
    end else if (hit) begin
      a.addr = off; a.wr = (kind == 0); a.wdata = wd; a.strb = st; a.keep = kp;
      acc_q.push_back(a);
      if (kind == 0) ref_mem[off] = wd;
      r.rdata = (kind == 1 && !mid_abort) ? ref_mem[off] : '0;
      r.err   = 1'b0;
      rsp_q.push_back(r);
      exp_n = 3 + lat;
    end else begin
      exp_n = 0;
    end
    drive(addr, kind, wd, st, kp);
    if (!hit) begin
      for (int i = 0; i < 20; i++) begin
        @(posedge abus_clk); #1;
        chk("miss_reg_req", 32'(reg_req),   32'h0);
        chk("miss_sack",    32'(abus_sack), 32'h0);
      end
      release_bus();
      return;
    end
    n = 0;
    while (!abus_sack && n < 50) begin
      @(posedge abus_clk); #1;
      n++;
      if (mid_abort && n == 1) abus_sabort = 1'b1;
    end
    chk("ack_latency", 32'(n), 32'(exp_n));
    for (int i = 0; i < int'($urandom_range(2)); i++) begin
      @(posedge abus_clk); #1;
      chk("sack_held", 32'(abus_sack), 32'h1);
    end
    release_bus();
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  hb;
    int          m;
    rsp_t        r;
    acc_t        ac;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      periph[i]  = '0;
    end
    abus_rstb = 1'b0;
    abus_sreq = 1'b0; abus_swrite = 1'b0; abus_sread = 1'b0; abus_sabort = 1'b0;
    abus_saddress = '0; abus_swdata = '0; abus_sstrb = '0; abus_skeep = '0;
    reg_ready = 1'b0; reg_rdata = '0;

    #12;
    chk("rst_reg_req",  32'(reg_req),     32'h0);
    chk("rst_sack",     32'(abus_sack),   32'h0);
    chk("rst_serr",     32'(abus_serr),   32'h0);
    chk("rst_srdata",   32'(abus_srdata), 32'h0);
    chk("rst_reg_addr", 32'(reg_addr),    32'h0);
    @(negedge abus_clk);
    abus_rstb = 1'b1;
    @(negedge abus_clk);

    txn(16'h4012, 0, 2, 1'b0, 16'hA5A5);
    txn(16'h40FF, 0, 0, 1'b0, 16'h1234);
    txn(16'h40FF, 1, 0, 1'b0, 16'h0000);
    txn(16'h4012, 1, 1, 1'b0, 16'h0000);
    txn(16'h4100, 1, 0, 1'b0, 16'h0000);
    txn(16'h4020, 2, 0, 1'b0, 16'h0000);
    txn(16'h4012, 1, 3, 1'b1, 16'h0000);
    txn(16'h4030, 0, 3, 1'b1, 16'hBEEF);
    txn(16'h4030, 1, 0, 1'b0, 16'h0000);

    // Asynchronous reset while the local access is outstanding.
    hold = 1'b1;
    ac.addr = 8'h44; ac.wr = 1'b1; ac.wdata = 16'h7777; ac.strb = 5'd3; ac.keep = 5'd4;
    acc_q.push_back(ac);
    drive(16'h4044, 0, 16'h7777, 5'd3, 5'd4);
    repeat (3) @(posedge abus_clk);
    #1;
    chk("pre_reset_req", 32'(reg_req), 32'h1);
    #2 abus_rstb = 1'b0;
    #1;
    chk("async_rst_req",  32'(reg_req),   32'h0);
    chk("async_rst_sack", 32'(abus_sack), 32'h0);
    abus_sreq = 1'b0; abus_swrite = 1'b0; abus_sread = 1'b0;
    @(negedge abus_clk);
    abus_rstb = 1'b1;
    hold = 1'b0;
    @(negedge abus_clk);
    txn(16'h4044, 1, 0, 1'b0, 16'h0000);

    // Local port that never answers.
    hold = 1'b1;
    ac.addr = 8'h55; ac.wr = 1'b0; ac.wdata = 16'h0; ac.strb = 5'd1; ac.keep = 5'd1;
    acc_q.push_back(ac);
`ifdef ABUS_SLAVE_TIMEOUT_EN
    r.rdata = '0; r.err = 1'b1; rsp_q.push_back(r);
`endif
    cur_lat = 0;
    drive(16'h4055, 1, 16'h0, 5'd1, 5'd1);
    @(posedge abus_clk); #1;
`ifdef ABUS_SLAVE_TIMEOUT_EN
    m = 0;
    while (reg_req && m < 50) begin
      @(posedge abus_clk); #1;
      m++;
    end
    chk("timeout_req_cycles", 32'(m), 32'(TMO));
    m = 0;
    while (!abus_sack && m < 10) begin
      @(posedge abus_clk); #1;
      m++;
    end
    chk("timeout_sack", 32'(abus_sack), 32'h1);
    chk("timeout_serr", 32'(abus_serr), 32'h1);
    release_bus();
    hold = 1'b0;
`else
    m = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge abus_clk); #1;
      if (reg_req && !abus_sack && !abus_serr) m++;
    end
    chk("still_waiting_cycles", 32'(m), 32'd100);
    r.rdata = ref_mem[8'h55]; r.err = 1'b0; rsp_q.push_back(r);
    hold = 1'b0;
    m = 0;
    while (!abus_sack && m < 10) begin
      @(posedge abus_clk); #1;
      m++;
    end
    chk("late_ready_sack", 32'(abus_sack), 32'h1);
    release_bus();
`endif

    // Randomised traffic.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(3) != 0) begin
        a = {BASE[15:8], 8'($urandom_range(255))};
      end else begin
        hb = 8'($urandom_range(255));
        if (hb == BASE[15:8]) hb = hb + 8'd1;
        a = {hb, 8'($urandom_range(255))};
      end
      txn(a, int'($urandom_range(2)), int'($urandom_range(3)),
          ($urandom_range(4) == 0), DW'($urandom));
    end

    chk("acc_q_empty", 32'(acc_q.size()), 32'h0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
